lock_ctrl: RTL and testbench

- Keypad-entry controller that sequences the 8-digit hex character buffer (charbuf) and implements a combination-lock state machine on top of it.
- Decodes keypad strobes into charbuf insert, backspace and clear pulses, and tracks the digit count.
- On ENTER, compares the buffer contents against a stored code, counts failed attempts, and holds an alarm lockout.
- While open, allows the code to be reprogrammed, and re-locks automatically on timeout.

---
 rtl/lock_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lock_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lock_ctrl.sv
// Keypad sequencer and combination lock driving an external 8-digit hex charbuf.
// Latency: cb_* pulses one cycle after the key strobe; VERIFY takes one cycle.
// Backpressure: none; keys arriving in VERIFY/ALARM or on the relock cycle are dropped.
module lock_ctrl #(
    parameter logic [31:0] DEFAULT_CODE = 32'h0000_1234,
    parameter int          DIGITS       = 8,
    parameter int          MAX_ATTEMPTS = 3,
    parameter int          OPEN_CYCLES  = 1000,
    parameter int          ALARM_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    input  logic [31:0] cb_out,
    input  logic        cb_is_empty,
    output logic        cb_enable,
    output logic        cb_clr,
    output logic        cb_bksp,
    output logic        cb_is_ctrl,
    output logic [3:0]  cb_in_char,
    output logic [2:0]  state,
    output logic        unlocked,
    output logic        alarm,
    output logic        fail,
    output logic        code_saved,
    output logic [1:0]  attempts_left,
    output logic [3:0]  digit_count
);
    typedef enum logic [2:0] {
        S_LOCKED = 3'd0,
        S_ENTRY  = 3'd1,
        S_VERIFY = 3'd2,
        S_OPEN   = 3'd3,
        S_ALARM  = 3'd4
    } state_t;

    localparam int OT_W = $clog2(OPEN_CYCLES + 1);
    localparam int AT_W = $clog2(ALARM_CYCLES + 1);

    localparam logic [4:0] K_ENTER = 5'h10;
    localparam logic [4:0] K_BKSP  = 5'h11;
    localparam logic [4:0] K_CLR   = 5'h12;
    localparam logic [4:0] K_LOCK  = 5'h13;

    state_t           state_q;
    logic [31:0]      code_q;
    logic [OT_W-1:0]  open_tmr;
    logic [AT_W-1:0]  alarm_tmr;
    logic             save_pend;

    logic timeout, accept, dig_ok, bksp_ok, clr_ok, enter_ok, lock_ok, fsm_clr;

    // The empty flag lags a just-issued digit by two edges, so digit_count is authoritative.
    logic unused_empty;
    assign unused_empty = cb_is_empty;

    assign timeout  = (state_q == S_OPEN) && (open_tmr == OT_W'(OPEN_CYCLES - 1));
    assign accept   = key_valid && (key_code <= K_LOCK) &&
                      ((state_q == S_LOCKED) || (state_q == S_ENTRY) ||
                       ((state_q == S_OPEN) && !timeout));
    assign dig_ok   = accept && !key_code[4] && (digit_count != 4'(DIGITS));
    assign bksp_ok  = accept && (key_code == K_BKSP) && (digit_count != 4'd0);
    assign clr_ok   = accept && (key_code == K_CLR);
    assign enter_ok = accept && (key_code == K_ENTER) && (digit_count != 4'd0);
    assign lock_ok  = accept && (key_code == K_LOCK);

    // Clears the controller itself requests: verify outcome, LOCK, code store, relock.
    assign fsm_clr  = (state_q == S_VERIFY) ||
                      ((state_q == S_ENTRY) && lock_ok) ||
                      ((state_q == S_OPEN) && (timeout || enter_ok || lock_ok));

    assign state    = state_q;
    assign unlocked = (state_q == S_OPEN);
    assign alarm    = (state_q == S_ALARM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_LOCKED;
            code_q        <= DEFAULT_CODE;
            attempts_left <= 2'(MAX_ATTEMPTS);
            digit_count   <= '0;
            open_tmr      <= '0;
            alarm_tmr     <= '0;
            save_pend     <= 1'b0;
            cb_enable     <= 1'b0;
            cb_clr        <= 1'b0;
            cb_bksp       <= 1'b0;
            cb_is_ctrl    <= 1'b0;
            cb_in_char    <= '0;
            fail          <= 1'b0;
            code_saved    <= 1'b0;
        end else begin
            cb_enable  <= 1'b0;
            cb_clr     <= 1'b0;
            cb_bksp    <= 1'b0;
            cb_is_ctrl <= 1'b0;
            cb_in_char <= '0;
            fail       <= 1'b0;
            code_saved <= 1'b0;
            save_pend  <= 1'b0;

            // cb_out lags the ENTER strobe by one cycle, so the store happens a cycle later.
            if (save_pend) begin
                code_q     <= cb_out;
                code_saved <= 1'b1;
            end

            if (dig_ok) begin
                cb_enable   <= 1'b1;
                cb_in_char  <= key_code[3:0];
                digit_count <= digit_count + 4'd1;
            end else if (bksp_ok) begin
                cb_enable   <= 1'b1;
                cb_bksp     <= 1'b1;
                cb_is_ctrl  <= 1'b1;
                digit_count <= digit_count - 4'd1;
            end else if (clr_ok || fsm_clr) begin
                cb_clr      <= 1'b1;
                cb_is_ctrl  <= 1'b1;
                digit_count <= '0;
            end

            case (state_q)
                S_LOCKED: begin
                    if (dig_ok) state_q <= S_ENTRY;
                end
                S_ENTRY: begin
                    if ((bksp_ok && digit_count == 4'd1) || clr_ok || lock_ok)
                        state_q <= S_LOCKED;
                    else if (enter_ok)
                        state_q <= S_VERIFY;
                end
                S_VERIFY: begin
                    if (cb_out == code_q) begin
                        state_q       <= S_OPEN;
                        attempts_left <= 2'(MAX_ATTEMPTS);
                        open_tmr      <= '0;
                    end else begin
                        fail          <= 1'b1;
                        attempts_left <= attempts_left - 2'd1;
                        if (attempts_left == 2'd1) begin
                            state_q   <= S_ALARM;
                            alarm_tmr <= '0;
                        end else begin
                            state_q   <= S_LOCKED;
                        end
                    end
                end
                S_OPEN: begin
                    if (timeout) begin
                        state_q <= S_LOCKED;
                    end else if (accept) begin
                        open_tmr <= '0;
                        if (enter_ok) save_pend <= 1'b1;
                        if (lock_ok)  state_q   <= S_LOCKED;
                    end else begin
                        open_tmr <= open_tmr + 1'b1;
                    end
                end
                S_ALARM: begin
                    if (alarm_tmr == AT_W'(ALARM_CYCLES - 1)) begin
                        state_q       <= S_LOCKED;
                        attempts_left <= 2'(MAX_ATTEMPTS);
                    end else begin
                        alarm_tmr <= alarm_tmr + 1'b1;
                    end
                end
                default: state_q <= S_LOCKED;
            endcase
        end
    end
endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl with a small behavioural charbuf on the cb_* interface.
`timescale 1ns/1ps
module tb_lock_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = '0;
    logic [31:0] cb_out;
    logic        cb_is_empty;
    logic        cb_enable, cb_clr, cb_bksp, cb_is_ctrl;
    logic [3:0]  cb_in_char;
    logic [2:0]  state;
    logic        unlocked, alarm, fail, code_saved;
    logic [1:0]  attempts_left;
    logic [3:0]  digit_count;
    logic [3:0]  cb_n;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lock_ctrl dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .cb_out(cb_out), .cb_is_empty(cb_is_empty),
        .cb_enable(cb_enable), .cb_clr(cb_clr), .cb_bksp(cb_bksp),
        .cb_is_ctrl(cb_is_ctrl), .cb_in_char(cb_in_char), .state(state),
        .unlocked(unlocked), .alarm(alarm), .fail(fail), .code_saved(code_saved),
        .attempts_left(attempts_left), .digit_count(digit_count)
    );

    // Charbuf stand-in: shifts digits in at the low nibble, backspace shifts right.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cb_out <= '0;
            cb_n   <= '0;
        end else if (cb_clr) begin
            cb_out <= '0;
            cb_n   <= '0;
        end else if (cb_enable && cb_bksp) begin
            cb_out <= cb_out >> 4;
            cb_n   <= cb_n - 4'd1;
        end else if (cb_enable && !cb_is_ctrl) begin
            cb_out <= {cb_out[27:0], cb_in_char};
            cb_n   <= cb_n + 4'd1;
        end
    end
    assign cb_is_empty = (cb_n == 4'd0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns one falling edge later with the key sampled.
    task automatic key(input logic [4:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic unlock_default();
        key(5'h1); key(5'h2); key(5'h3); key(5'h4); key(5'h10);
        idle(1);
    endtask

    initial begin
        idle(2);
        chk("rst_state", state, 0);
        chk("rst_attempts", attempts_left, 3);
        chk("rst_count", digit_count, 0);
        chk("rst_cb", {cb_enable, cb_clr, cb_bksp, cb_is_ctrl, cb_in_char}, 0);
        chk("rst_pulses", {fail, code_saved}, 0);
        rst = 1'b1;
        idle(1);

        // Default code unlock, checking each digit pulse
        for (int i = 1; i <= 4; i++) begin
            key(5'(i));
            chk("dig_en", {cb_enable, cb_is_ctrl}, 2'b10);
            chk("dig_char", cb_in_char, 32'(i));
            chk("dig_state", state, 1);
        end
        key(5'h10);
        chk("enter_verify", state, 2);
        idle(1);
        chk("open_state", state, 3);
        chk("open_unlocked", unlocked, 1);
        chk("open_clr", cb_clr, 1);
        chk("open_count", digit_count, 0);
        key(5'h13);
        chk("lock_clr", cb_clr, 1);
        chk("lock_state", state, 0);

        // Three wrong attempts into ALARM
        for (int i = 0; i < 3; i++) begin
            key(5'h9); key(5'h9); key(5'h10);
            idle(1);
            chk("bad_fail", fail, 1);
            chk("bad_attempts", attempts_left, 32'(2 - i));
            chk("bad_state", state, (i == 2) ? 32'd4 : 32'd0);
        end
        chk("alarm_flag", alarm, 1);
        key(5'h5);
        chk("alarm_drop", {cb_enable, cb_clr, cb_bksp, cb_is_ctrl}, 0);
        chk("alarm_count", digit_count, 0);
        idle(498);
        chk("alarm_hold", state, 4);
        idle(1);
        chk("alarm_exit", state, 0);
        chk("alarm_attempts", attempts_left, 3);

        // Backspace editing then unlock
        key(5'h1); key(5'h2); key(5'h5);
        chk("edit_count3", digit_count, 3);
        key(5'h11);
        chk("bksp_pulse", {cb_enable, cb_bksp, cb_is_ctrl}, 3'b111);
        chk("bksp_count", digit_count, 2);
        key(5'h3); key(5'h4); key(5'h10);
        idle(1);
        chk("edit_open", state, 3);
        key(5'h13);
        key(5'h1); key(5'h2); key(5'h12);
        chk("clr_pulse", {cb_clr, cb_is_ctrl}, 2'b11);
        chk("clr_count", digit_count, 0);
        chk("clr_state", state, 0);

        // Capacity and backspace-at-empty
        for (int i = 1; i <= 8; i++) key(5'(i));
        key(5'h9);
        chk("full_drop", cb_enable, 0);
        chk("full_count", digit_count, 8);
        chk("full_buf", cb_out, 32'h1234_5678);
        key(5'h12);
        chk("full_clr_state", state, 0);
        key(5'h11);
        chk("empty_bksp", {cb_enable, cb_bksp}, 0);

        // Reprogram to 0xAB, then reset restores the default code
        unlock_default();
        chk("rp_open", state, 3);
        key(5'hA); key(5'hB); key(5'h10);
        chk("rp_stay_open", state, 3);
        chk("rp_clr", cb_clr, 1);
        idle(1);
        chk("rp_saved", code_saved, 1);
        key(5'h13);
        unlock_default();
        chk("rp_old_fail", fail, 1);
        chk("rp_old_state", state, 0);
        chk("rp_old_attempts", attempts_left, 2);
        key(5'hA); key(5'hB); key(5'h10);
        idle(1);
        chk("rp_new_open", state, 3);
        chk("rp_new_attempts", attempts_left, 3);
        rst = 1'b0;
        idle(1);
        chk("rp_rst_state", state, 0);
        rst = 1'b1;
        unlock_default();
        chk("rp_default_open", state, 3);

        // A key mid-way restarts the relock timer
        idle(600);
        key(5'h7);
        chk("tmr_key_count", digit_count, 1);
        idle(999);
        chk("tmr_hold", state, 3);
        idle(1);
        chk("tmr_relock", state, 0);
        chk("tmr_relock_clr", cb_clr, 1);
        chk("tmr_relock_count", digit_count, 0);

        // Key on the timeout cycle is dropped
        unlock_default();
        idle(999);
        chk("to_hold", state, 3);
        key(5'h5);
        chk("to_state", state, 0);
        chk("to_drop", {cb_enable, cb_clr}, 2'b01);
        chk("to_count", digit_count, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
